// File: rtl/tag_dir_pkg.sv
// Shared sizes and types for the directory tag SRAM front end.
// One SRAM row holds WAYS entries of {valid, tag}, with way 0 in the LSBs.
package tag_dir_pkg;
  localparam int SETS       = 1024;
  localparam int WAYS       = 8;
  localparam int ENTRY_W    = 20;
  localparam int TAG_W      = ENTRY_W - 1;
  localparam int SET_W      = $clog2(SETS);
  localparam int WAY_W      = $clog2(WAYS);
  localparam int ROW_W      = WAYS * ENTRY_W;
  localparam int RESP_DEPTH = 2;
  localparam int MAX_WSTALL = 4;
  localparam int FIFO_CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int STALL_W    = $clog2(MAX_WSTALL + 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef struct packed {
    logic             hit;
    logic [WAY_W-1:0] way;
    logic             multi;
    logic [ROW_W-1:0] entries;
  } tag_resp_t;

  // Lowest set bit wins; returns 0 when nothing is set.
  function automatic logic [WAY_W-1:0] lowest_way(input logic [WAYS-1:0] v);
    logic [WAY_W-1:0] res;
    res = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) res = WAY_W'(i);
    end
    return res;
  endfunction
endpackage

// File: rtl/tag_resp_fifo.sv
// Small circular response FIFO with occupancy count.
// Enqueue alongside dequeue is accepted even when full.
module tag_resp_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [WIDTH-1:0] deq_data,
  output logic             not_empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_enq, do_deq;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_deq    = deq & (cnt_q != '0);
  assign do_enq    = enq & ((cnt_q != CNT_W'(DEPTH)) | do_deq);
  assign deq_data  = mem_q[rd_ptr_q];
  assign not_empty = (cnt_q != '0);
  assign count     = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = do_deq ? bump(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_enq ? bump(wr_ptr_q) : wr_ptr_q;
    cnt_d    = cnt_q + CNT_W'(do_enq) - CNT_W'(do_deq);
    if (do_enq) mem_d[wr_ptr_q] = enq_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/tag_read_ctrl.sv
// Directory tag SRAM front end: arbitrates tag writes against lookups,
// issues reads under a response credit, matches the returned set and queues results.
module tag_read_ctrl
  import tag_dir_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               io_req_valid,
  output logic               io_req_ready,
  input  logic [SET_W-1:0]   io_req_bits_set,
  input  logic [TAG_W-1:0]   io_req_bits_tag,
  output logic               io_resp_valid,
  input  logic               io_resp_ready,
  output logic               io_resp_bits_hit,
  output logic [WAY_W-1:0]   io_resp_bits_way,
  output logic               io_resp_bits_multi,
  output logic [ROW_W-1:0]   io_resp_bits_entries,
  input  logic               io_tagw_valid,
  output logic               io_tagw_ready,
  input  logic [SET_W-1:0]   io_tagw_bits_set,
  input  logic [ROW_W-1:0]   io_tagw_bits_data,
  input  logic [WAYS-1:0]    io_tagw_bits_waymask,
  output logic               sram_rreq_valid,
  output logic [SET_W-1:0]   sram_rreq_setIdx,
  input  logic [ROW_W-1:0]   sram_rdata,
  output logic               sram_wreq_valid,
  output logic [SET_W-1:0]   sram_wreq_setIdx,
  output logic [ROW_W-1:0]   sram_wreq_data,
  output logic [WAYS-1:0]    sram_wreq_waymask
);
  localparam int CRED_W = FIFO_CNT_W + 1;

  logic                  active_q, active_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [SET_W-1:0]      pend_set_q, pend_set_d;
  logic [TAG_W-1:0]      pend_tag_q, pend_tag_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0]      s1_tag_q, s1_tag_d;
  logic [STALL_W-1:0]    wstall_q, wstall_d;

  logic                  force_read, req_fire, resp_fire, lk_valid, can_issue, issue;
  logic [SET_W-1:0]      lk_set;
  logic [TAG_W-1:0]      lk_tag;
  logic [FIFO_CNT_W-1:0] fifo_cnt;
  logic [CRED_W-1:0]     credit_used;
  logic [WAYS-1:0]       hit_w;
  tag_resp_t             s1_resp, head;

  assign force_read      = (wstall_q >= STALL_W'(MAX_WSTALL));
  assign io_tagw_ready   = active_q & ~force_read;
  assign sram_wreq_valid = io_tagw_valid & io_tagw_ready;
  assign sram_wreq_setIdx  = sram_wreq_valid ? io_tagw_bits_set     : '0;
  assign sram_wreq_data    = sram_wreq_valid ? io_tagw_bits_data    : '0;
  assign sram_wreq_waymask = sram_wreq_valid ? io_tagw_bits_waymask : '0;

  assign io_req_ready = active_q & ~pend_valid_q;
  assign req_fire     = io_req_valid & io_req_ready;
  assign resp_fire    = io_resp_valid & io_resp_ready;
  assign lk_valid     = pend_valid_q | req_fire;
  assign lk_set       = pend_valid_q ? pend_set_q : io_req_bits_set;
  assign lk_tag       = pend_valid_q ? pend_tag_q : io_req_bits_tag;

  // Entries already committed to the FIFO path, net of the one leaving this cycle.
  assign credit_used = {1'b0, fifo_cnt} + CRED_W'(s1_valid_q) - CRED_W'(resp_fire);
  assign can_issue   = (credit_used < CRED_W'(RESP_DEPTH));
  assign issue       = lk_valid & can_issue & ~sram_wreq_valid;

  assign sram_rreq_valid  = issue;
  assign sram_rreq_setIdx = issue ? lk_set : '0;

  always_comb begin
    active_d     = 1'b1;
    pend_valid_d = pend_valid_q;
    pend_set_d   = pend_set_q;
    pend_tag_d   = pend_tag_q;
    if (req_fire && !issue) begin
      pend_valid_d = 1'b1;
      pend_set_d   = io_req_bits_set;
      pend_tag_d   = io_req_bits_tag;
    end else if (pend_valid_q && issue) begin
      pend_valid_d = 1'b0;
    end
    s1_valid_d = issue;
    s1_tag_d   = issue ? lk_tag : s1_tag_q;
    wstall_d   = wstall_q;
    if (issue)                               wstall_d = '0;
    else if (pend_valid_q && sram_wreq_valid) wstall_d = wstall_q + STALL_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_set_q   <= '0;
      pend_tag_q   <= '0;
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= '0;
      wstall_q     <= '0;
    end else begin
      active_q     <= active_d;
      pend_valid_q <= pend_valid_d;
      pend_set_q   <= pend_set_d;
      pend_tag_q   <= pend_tag_d;
      s1_valid_q   <= s1_valid_d;
      s1_tag_q     <= s1_tag_d;
      wstall_q     <= wstall_d;
    end
  end

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
    tag_entry_t entry;
    assign entry     = sram_rdata[gi*ENTRY_W +: ENTRY_W];
    assign hit_w[gi] = entry.valid & (entry.tag == s1_tag_q);
  end

  always_comb begin
    s1_resp.hit     = |hit_w;
    s1_resp.way     = lowest_way(hit_w);
    s1_resp.multi   = |(hit_w & (hit_w - WAYS'(1)));
    s1_resp.entries = sram_rdata;
  end

  tag_resp_fifo #(
    .WIDTH ($bits(tag_resp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq       (s1_valid_q),
    .enq_data  (s1_resp),
    .deq       (resp_fire),
    .deq_data  (head),
    .not_empty (io_resp_valid),
    .count     (fifo_cnt)
  );

  assign io_resp_bits_hit     = head.hit;
  assign io_resp_bits_way     = head.way;
  assign io_resp_bits_multi   = head.multi;
  assign io_resp_bits_entries = head.entries;
endmodule

// File: tb/tb_tag_read_ctrl.sv
// Directed bench for tag_read_ctrl with a behavioural 1-port write-priority SRAM.
module tb_tag_read_ctrl;
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         io_req_valid = 1'b0;
  logic         io_req_ready;
  logic [9:0]   io_req_bits_set = '0;
  logic [18:0]  io_req_bits_tag = '0;
  logic         io_resp_valid;
  logic         io_resp_ready = 1'b1;
  logic         io_resp_bits_hit;
  logic [2:0]   io_resp_bits_way;
  logic         io_resp_bits_multi;
  logic [159:0] io_resp_bits_entries;
  logic         io_tagw_valid = 1'b0;
  logic         io_tagw_ready;
  logic [9:0]   io_tagw_bits_set = '0;
  logic [159:0] io_tagw_bits_data = '0;
  logic [7:0]   io_tagw_bits_waymask = '0;
  logic         sram_rreq_valid;
  logic [9:0]   sram_rreq_setIdx;
  logic [159:0] sram_rdata = '0;
  logic         sram_wreq_valid;
  logic [9:0]   sram_wreq_setIdx;
  logic [159:0] sram_wreq_data;
  logic [7:0]   sram_wreq_waymask;

  logic [159:0] mem [0:1023];
  logic         mem_clr = 1'b1;
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 clock = ~clock;

  tag_read_ctrl dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_bits_set(io_req_bits_set), .io_req_bits_tag(io_req_bits_tag),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_bits_hit(io_resp_bits_hit), .io_resp_bits_way(io_resp_bits_way),
    .io_resp_bits_multi(io_resp_bits_multi), .io_resp_bits_entries(io_resp_bits_entries),
    .io_tagw_valid(io_tagw_valid), .io_tagw_ready(io_tagw_ready),
    .io_tagw_bits_set(io_tagw_bits_set), .io_tagw_bits_data(io_tagw_bits_data),
    .io_tagw_bits_waymask(io_tagw_bits_waymask),
    .sram_rreq_valid(sram_rreq_valid), .sram_rreq_setIdx(sram_rreq_setIdx),
    .sram_rdata(sram_rdata),
    .sram_wreq_valid(sram_wreq_valid), .sram_wreq_setIdx(sram_wreq_setIdx),
    .sram_wreq_data(sram_wreq_data), .sram_wreq_waymask(sram_wreq_waymask)
  );

  // SRAM model: write priority, read data only in the cycle after the request.
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int s = 0; s < 1024; s++) mem[s] <= '0;
      sram_rdata <= '0;
    end else begin
      if (sram_wreq_valid) begin
        for (int w = 0; w < 8; w++)
          if (sram_wreq_waymask[w]) mem[sram_wreq_setIdx][w*20 +: 20] <= sram_wreq_data[w*20 +: 20];
      end
      if (sram_rreq_valid && !sram_wreq_valid) sram_rdata <= mem[sram_rreq_setIdx];
      else                                     sram_rdata <= '0;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [159:0] way_entry(input int w, input logic v, input logic [18:0] t);
    logic [159:0] d;
    d = '0;
    d[w*20 +: 20] = {v, t};
    return d;
  endfunction

  task automatic check_resp(input string nm, input logic eh, input logic [2:0] ew, input logic em);
    $display("resp %s: valid=%0d hit=%0d way=%0d multi=%0d", nm, io_resp_valid,
             io_resp_bits_hit, io_resp_bits_way, io_resp_bits_multi);
    check_val({nm, "_valid"}, io_resp_valid, 1);
    check_val({nm, "_hit"}, io_resp_bits_hit, eh);
    check_val({nm, "_way"}, io_resp_bits_way, ew);
    check_val({nm, "_multi"}, io_resp_bits_multi, em);
  endtask

  task automatic do_write(input logic [9:0] set, input logic [159:0] data, input logic [7:0] mask);
    int n;
    n = 0;
    io_tagw_valid = 1'b1;
    io_tagw_bits_set = set;
    io_tagw_bits_data = data;
    io_tagw_bits_waymask = mask;
    #1;
    while (!io_tagw_ready && n < 20) begin
      next_cycle();
      n++;
    end
    $display("write set=%0d mask=0x%0h", set, mask);
    check_val("tagw_fire", sram_wreq_valid, 1);
    next_cycle();
    io_tagw_valid = 1'b0;
  endtask

  task automatic lookup_expect(input string nm, input logic [9:0] set, input logic [18:0] tag,
                               input logic eh, input logic [2:0] ew, input logic em);
    io_req_valid = 1'b1;
    io_req_bits_set = set;
    io_req_bits_tag = tag;
    #1;
    check_val({nm, "_req_ready"}, io_req_ready, 1);
    check_val({nm, "_issue"}, sram_rreq_valid, 1);
    next_cycle();
    io_req_valid = 1'b0;
    #1;
    check_val({nm, "_t1_valid"}, io_resp_valid, 0);
    next_cycle();
    check_resp(nm, eh, ew, em);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  tp_set [3];
    logic [18:0] tp_tag [3];
    logic [2:0]  tp_way [3];
    logic        tp_multi [3];
    tp_set = '{10'd3, 10'd9, 10'd7};
    tp_tag = '{19'h1234, 19'h0ABC, 19'h0777};
    tp_way = '{3'd5, 3'd2, 3'd1};
    tp_multi = '{1'b0, 1'b1, 1'b0};

    // Reset state
    #3;
    check_val("rst_req_ready", io_req_ready, 0);
    check_val("rst_tagw_ready", io_tagw_ready, 0);
    check_val("rst_resp_valid", io_resp_valid, 0);
    check_val("rst_rreq_valid", sram_rreq_valid, 0);
    check_val("rst_wreq_valid", sram_wreq_valid, 0);
    check_val("rst_resp_way", io_resp_bits_way, 0);
    next_cycle();
    mem_clr = 1'b0;
    reset = 1'b1;
    next_cycle();
    next_cycle();
    check_val("idle_req_ready", io_req_ready, 1);
    check_val("idle_tagw_ready", io_tagw_ready, 1);

    // Single hit, miss-by-valid and multi-hit
    do_write(10'd3, way_entry(5, 1'b1, 19'h1234), 8'h20);
    do_write(10'd9, way_entry(2, 1'b1, 19'h0ABC) | way_entry(6, 1'b1, 19'h0ABC), 8'h44);
    do_write(10'd10, way_entry(4, 1'b0, 19'h0ABC), 8'h10);
    io_req_valid = 1'b1;
    io_req_bits_set = 10'd3;
    io_req_bits_tag = 19'h1234;
    #1;
    check_val("hit5_issue", sram_rreq_valid, 1);
    next_cycle();
    io_req_valid = 1'b0;
    #1;
    check_val("hit5_t1_valid", io_resp_valid, 0);
    next_cycle();
    check_resp("hit5", 1'b1, 3'd5, 1'b0);
    check_val("hit5_entry", io_resp_bits_entries[100 +: 20], 20'h81234);
    next_cycle();
    lookup_expect("multi", 10'd9, 19'h0ABC, 1'b1, 3'd2, 1'b1);
    lookup_expect("invalid", 10'd10, 19'h0ABC, 1'b0, 3'd0, 1'b0);

    // Lookup collides with a write to the same set: pending, then sees the new data
    io_tagw_valid = 1'b1;
    io_tagw_bits_set = 10'd7;
    io_tagw_bits_data = way_entry(1, 1'b1, 19'h0777);
    io_tagw_bits_waymask = 8'h02;
    io_req_valid = 1'b1;
    io_req_bits_set = 10'd7;
    io_req_bits_tag = 19'h0777;
    #1;
    check_val("coll_wfire", sram_wreq_valid, 1);
    check_val("coll_req_ready", io_req_ready, 1);
    check_val("coll_no_issue", sram_rreq_valid, 0);
    next_cycle();
    io_tagw_valid = 1'b0;
    io_req_valid = 1'b0;
    #1;
    check_val("coll_retry", sram_rreq_valid, 1);
    check_val("coll_retry_set", sram_rreq_setIdx, 7);
    check_val("coll_pend_ready", io_req_ready, 0);
    next_cycle();
    check_val("coll_t2_valid", io_resp_valid, 0);
    next_cycle();
    check_resp("coll", 1'b1, 3'd1, 1'b0);
    next_cycle();

    // Starvation guard: writes held high against a pending lookup
    io_tagw_valid = 1'b1;
    io_tagw_bits_set = 10'd20;
    io_tagw_bits_data = way_entry(0, 1'b1, 19'h00055);
    io_tagw_bits_waymask = 8'h01;
    for (int k = 0; k < 7; k++) begin
      io_req_valid = (k == 0);
      io_req_bits_set = 10'd21;
      io_req_bits_tag = 19'h00005;
      #1;
      check_val($sformatf("stall_c%0d_tagw_ready", k), io_tagw_ready, (k == 5) ? 0 : 1);
      check_val($sformatf("stall_c%0d_rreq", k), sram_rreq_valid, (k == 5) ? 1 : 0);
      next_cycle();
    end
    io_tagw_valid = 1'b0;
    #1;
    check_resp("stall", 1'b0, 3'd0, 1'b0);
    next_cycle();
    next_cycle();

    // Sustained throughput: one response per cycle
    for (int k = 0; k < 5; k++) begin
      io_req_valid = (k < 3);
      if (k < 3) begin
        io_req_bits_set = tp_set[k];
        io_req_bits_tag = tp_tag[k];
      end
      #1;
      if (k < 3) check_val($sformatf("tput_issue%0d", k), sram_rreq_valid, 1);
      if (k >= 2) check_resp($sformatf("tput%0d", k - 2), 1'b1, tp_way[k-2], tp_multi[k-2]);
      next_cycle();
    end
    #1;
    check_val("tput_drained", io_resp_valid, 0);

    // Backpressure: FIFO full, one pending, then drain in order
    io_resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      io_req_valid = 1'b1;
      io_req_bits_set = (k == 3) ? 10'd10 : tp_set[k];
      io_req_bits_tag = (k == 3) ? 19'h0ABC : tp_tag[k];
      #1;
      if (k == 2) begin
        check_val("bp_l2_accept", io_req_ready, 1);
        check_val("bp_l2_no_issue", sram_rreq_valid, 0);
      end
      if (k == 3) begin
        check_val("bp_l3_req_ready", io_req_ready, 0);
        check_val("bp_l3_resp_valid", io_resp_valid, 1);
      end
      next_cycle();
    end
    io_req_valid = 1'b0;
    #1;
    check_val("bp_hold_req_ready", io_req_ready, 0);
    check_val("bp_hold_way", io_resp_bits_way, 5);
    check_val("bp_hold_rreq", sram_rreq_valid, 0);
    next_cycle();
    io_resp_ready = 1'b1;
    #1;
    check_resp("bp0", 1'b1, 3'd5, 1'b0);
    check_val("bp_pend_issue", sram_rreq_valid, 1);
    next_cycle();
    check_resp("bp1", 1'b1, 3'd2, 1'b1);
    check_val("bp_req_ready_back", io_req_ready, 1);
    next_cycle();
    check_resp("bp2", 1'b1, 3'd1, 1'b0);
    next_cycle();
    check_val("bp_drained", io_resp_valid, 0);

    // Reset with a read in flight and the FIFO non-empty
    io_resp_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      io_req_valid = 1'b1;
      io_req_bits_set = tp_set[k];
      io_req_bits_tag = tp_tag[k];
      next_cycle();
    end
    io_req_valid = 1'b0;
    #1;
    check_val("mid_pre_resp_valid", io_resp_valid, 1);
    reset = 1'b0;
    #1;
    check_val("mid_rst_resp_valid", io_resp_valid, 0);
    check_val("mid_rst_rreq", sram_rreq_valid, 0);
    check_val("mid_rst_req_ready", io_req_ready, 0);
    check_val("mid_rst_tagw_ready", io_tagw_ready, 0);
    next_cycle();
    reset = 1'b1;
    io_resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_val($sformatf("post_rst_quiet%0d", k), io_resp_valid, 0);
      next_cycle();
    end
    lookup_expect("post_rst", 10'd3, 19'h1234, 1'b1, 3'd5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
